ddr3_cmd_queue: RTL and testbench
=================================

Name: ddr3_cmd_queue

Overview:
- Request buffer and issue sequencer between cpu_model and DDR3_Controller.
- Accepts CPU read/write requests with a valid/ready handshake and stores them in an in-order FIFO.
- Issues one command at a time to the controller and waits for completion before issuing the next.
- Returns read data to the CPU as a one-cycle response pulse.

Parameters:
- ADDR_W, 27, CPU byte-address width forwarded to the controller.
- DATA_W, 64, one BL8 burst of x8 data per request.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT, 1023, WAIT_DONE watchdog limit in cycles; used only with CMD_TIMEOUT_EN.

Ports:
- i_cpu_ck  in  1  system clock; all logic on its rising edge.
- i_cpu_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  CPU request valid.
- o_req_ready  out  1  queue can accept; equals !o_q_full.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  request address.
- i_req_wdata  in  DATA_W  write data; ignored for reads.
- o_cmd_valid  out  1  command presented to the controller.
- i_cmd_ack  in  1  controller accepted the command.
- o_cmd_we  out  1  command type.
- o_cmd_addr  out  ADDR_W  command address.
- o_cmd_wdata  out  DATA_W  command write data.
- i_cmd_done  in  1  controller finished the command; 1-cycle pulse.
- i_cmd_rdata  in  DATA_W  read data, valid with i_cmd_done on reads.
- o_rsp_valid  out  1  one-cycle read-response pulse.
- o_rsp_rdata  out  DATA_W  read response data.
- o_q_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_q_full  out  1  count == DEPTH.
- o_q_empty  out  1  count == 0.

Behaviour:
- Reset values:
  - all outputs 0, except o_q_empty=1 and o_req_ready=1;
  - FIFO pointers and count 0;
  - state IDLE.
- Push:
  - push occurs when i_req_valid && o_req_ready at a clock edge;
  - entry {we, addr, wdata} is written at the tail;
  - count updates on the same edge.
- o_req_ready is combinational from registered count. A pop in the same cycle does not raise ready when full.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - if !o_q_empty, pop the head into the o_cmd_* holding registers;
  - assert o_cmd_valid next cycle;
  - go to ISSUE.
- ISSUE:
  - o_cmd_valid=1 and o_cmd_* held stable until i_cmd_ack;
  - on ack, drop o_cmd_valid the next cycle and go to WAIT_DONE.
- WAIT_DONE:
  - on i_cmd_done, if the command is a read, o_rsp_valid=1 for exactly one cycle with o_rsp_rdata=i_cmd_rdata registered;
  - on i_cmd_done, go to IDLE.
- Latency:
  - a request pushed at edge N reaches o_cmd_valid at edge N+2 when the queue was empty and the FSM was IDLE;
  - the minimum gap between two commands is 2 cycles after done (done -> IDLE -> ISSUE).
- i_cmd_done outside WAIT_DONE is ignored. i_cmd_ack outside ISSUE is ignored.
- Simultaneous push and pop:
  - count is unchanged;
  - both pointers advance modulo DEPTH;
  - on an empty queue, the new entry is not poppable until the next cycle (no bypass).
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.
- Reset mid-operation:
  - immediate clear;
  - the in-flight command and queued entries are dropped;
  - o_cmd_valid and o_rsp_valid fall asynchronously.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- With CMD_TIMEOUT_EN:
  - a cycle counter runs in WAIT_DONE;
  - when it reaches TIMEOUT without i_cmd_done, sticky output o_timeout_err (1 bit) sets and the FSM returns to IDLE;
  - no response is generated for the timed-out command;
  - o_timeout_err clears only on reset.
- Without CMD_TIMEOUT_EN: no counter, no o_timeout_err port, and WAIT_DONE waits indefinitely.

Decomposition:
- Package ddr3_cmd_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_DONE);
  - the packed struct cmd_t {we, addr, wdata}, parameterised by package constants ADDR_W_DEF and DATA_W_DEF.
- One sub-module, ddr3_sync_fifo:
  - parameterised DEPTH and entry width;
  - provides push/pop/count/full/empty;
  - the FSM and holding registers live in ddr3_cmd_queue.

Test Plan:
1. Single write: push we=1, addr=0x100, wdata=0xA5A5_0000_0000_5A5A with ack 1 cycle later and done 4 cycles later -> o_cmd_valid rises exactly 2 cycles after push, o_rsp_valid stays 0, o_q_empty=1 at end.
2. Read return: push read addr=0x200; controller returns done with rdata=0x1234_5678_9ABC_DEF0 -> o_rsp_valid one-cycle pulse carrying that data, 1 cycle after done.
3. Full: hold ack low and push 9 requests (DEPTH=8) -> 1 popped into the holding register, 8 queued, o_q_full=1, o_req_ready=0, 10th push refused; then retire all -> commands issued in push order with no loss.
4. Backpressure: delay i_cmd_ack by 5 cycles -> o_cmd_addr/we/wdata stable throughout ISSUE, o_cmd_valid drops the cycle after ack.
5. Mid-op reset: assert i_cpu_rst_n=0 in WAIT_DONE with 3 entries queued -> outputs cleared immediately, o_q_count=0; a post-reset request issues normally.
6. With CMD_TIMEOUT_EN and TIMEOUT=16: withhold i_cmd_done -> o_timeout_err=1 after 16 WAIT_DONE cycles, the next queued command issues, and o_timeout_err stays set.

Source files
------------

// File: rtl/ddr3_cmd_pkg.sv
// ddr3_cmd_pkg
// Shared types for the DDR3 command queue: the issue-sequencer state
// encoding and the packed request layout {we, addr, wdata} at the default
// widths. The queue stores requests in exactly this bit order.
package ddr3_cmd_pkg;

    localparam int ADDR_W_DEF = 27;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ddr3_sync_fifo.sv
// ddr3_sync_fifo
// Single-clock in-order FIFO with registered occupancy.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write an entry at the tail (ignored when full)
//   pop               advance the head (ignored when empty)
//   head              entry at the head, valid while !empty
//   count, full, empty occupancy and its derived flags
// A push into an empty FIFO is not visible at head until the next cycle,
// because empty is derived from the registered count.
module ddr3_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 92
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guarding here keeps count within 0..DEPTH whatever the caller does.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ddr3_cmd_queue.sv
// ddr3_cmd_queue
// Request buffer and issue sequencer between the CPU model and the DDR3
// controller. CPU requests are queued in order, issued one at a time, and
// each must complete before the next is issued. Reads return data as a
// one-cycle response pulse.
// Ports:
//   i_cpu_ck, i_cpu_rst_n          clock, asynchronous active-low reset
//   i_req_* / o_req_ready          CPU request handshake
//   o_cmd_* / i_cmd_ack            command to the controller, held until ack
//   i_cmd_done, i_cmd_rdata        completion pulse and read data
//   o_rsp_valid, o_rsp_rdata       read response pulse
//   o_q_count, o_q_full, o_q_empty queue occupancy
// Optional feature, macro CMD_TIMEOUT_EN: adds parameter TIMEOUT and the
// sticky output o_timeout_err; a command whose done never arrives is
// abandoned after TIMEOUT cycles in WAIT_DONE without a response.
module ddr3_cmd_queue
    import ddr3_cmd_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 8
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input  logic                   i_cpu_ck,
    input  logic                   i_cpu_rst_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_we,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [DATA_W-1:0]      i_req_wdata,
    output logic                   o_cmd_valid,
    input  logic                   i_cmd_ack,
    output logic                   o_cmd_we,
    output logic [ADDR_W-1:0]      o_cmd_addr,
    output logic [DATA_W-1:0]      o_cmd_wdata,
    input  logic                   i_cmd_done,
    input  logic [DATA_W-1:0]      i_cmd_rdata,
    output logic                   o_rsp_valid,
    output logic [DATA_W-1:0]      o_rsp_rdata,
`ifdef CMD_TIMEOUT_EN
    output logic                   o_timeout_err,
`endif
    output logic [$clog2(DEPTH):0] o_q_count,
    output logic                   o_q_full,
    output logic                   o_q_empty
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    state_t               state;
    logic [ENTRY_W-1:0]   entry_in;
    logic [ENTRY_W-1:0]   head;
    logic                 push;
    logic                 pop;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]        wd_cnt;
`endif

    assign entry_in    = {i_req_we, i_req_addr, i_req_wdata};
    assign o_req_ready = !o_q_full;
    assign push        = i_req_valid && o_req_ready;
    // Popping only from IDLE gives exactly one command in flight.
    assign pop         = (state == IDLE) && !o_q_empty;

    ddr3_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (i_cpu_ck),
        .rst_n     (i_cpu_rst_n),
        .push      (push),
        .push_data (entry_in),
        .pop       (pop),
        .head      (head),
        .count     (o_q_count),
        .full      (o_q_full),
        .empty     (o_q_empty)
    );

    always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
        if (!i_cpu_rst_n) begin
            state       <= IDLE;
            o_cmd_valid <= 1'b0;
            o_cmd_we    <= 1'b0;
            o_cmd_addr  <= '0;
            o_cmd_wdata <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
`ifdef CMD_TIMEOUT_EN
            wd_cnt        <= '0;
            o_timeout_err <= 1'b0;
`endif
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!o_q_empty) begin
                        {o_cmd_we, o_cmd_addr, o_cmd_wdata} <= head;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // First ISSUE cycle raises valid; an ack only counts
                    // once valid is visible to the controller.
                    if (!o_cmd_valid) begin
                        o_cmd_valid <= 1'b1;
                    end else if (i_cmd_ack) begin
                        o_cmd_valid <= 1'b0;
                        state       <= WAIT_DONE;
`ifdef CMD_TIMEOUT_EN
                        wd_cnt      <= '0;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (i_cmd_done) begin
                        state <= IDLE;
                        if (!o_cmd_we) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= i_cmd_rdata;
                        end
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                        o_timeout_err <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_queue.sv
// tb_ddr3_cmd_queue
// Directed scenarios plus a randomized phase for ddr3_cmd_queue. A
// reference model keeps the accepted requests as a queue: every command the
// DUT presents must be the oldest outstanding request, reads must return
// the data the bench's controller supplied, and the occupancy flags must
// agree with the number of requests not yet issued.
// Build with +define+CMD_TIMEOUT_EN to exercise the watchdog (TIMEOUT=16).
module tb_ddr3_cmd_queue;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req_valid, i_req_we;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_wdata;
    logic              o_req_ready, o_cmd_valid, o_cmd_we;
    logic [ADDR_W-1:0] o_cmd_addr;
    logic [DATA_W-1:0] o_cmd_wdata, i_cmd_rdata, o_rsp_rdata;
    logic              i_cmd_ack, i_cmd_done, o_rsp_valid;
    logic [3:0]        o_q_count;
    logic              o_q_full, o_q_empty;
`ifdef CMD_TIMEOUT_EN
    logic              o_timeout_err;
`endif

    always #5 clk = ~clk;

    ddr3_cmd_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
`ifdef CMD_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .i_cpu_ck     (clk),
        .i_cpu_rst_n  (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_cmd_valid  (o_cmd_valid),
        .i_cmd_ack    (i_cmd_ack),
        .o_cmd_we     (o_cmd_we),
        .o_cmd_addr   (o_cmd_addr),
        .o_cmd_wdata  (o_cmd_wdata),
        .i_cmd_done   (i_cmd_done),
        .i_cmd_rdata  (i_cmd_rdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
`ifdef CMD_TIMEOUT_EN
        .o_timeout_err(o_timeout_err),
`endif
        .o_q_count    (o_q_count),
        .o_q_full     (o_q_full),
        .o_q_empty    (o_q_empty)
    );

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t        model_q[$];
    req_t        cur, nxt_req;
    int          checks = 0;
    int          errors = 0;
    bit          will_accept, ack_drv, done_drv, waiting, prev_valid;
    bit          hold_ack, hold_done, rand_delays, fixed_rdata_en;
    int          ack_delay, done_delay, ack_cnt, done_cnt;
    int          hi_len, issued, rsp_cnt;
    logic [63:0] done_data, fixed_rdata, last_rsp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture acceptance, advance the edge, check, then play the
    // controller for the following edge.
    task automatic tick();
        int          pending;
        logic [63:0] exp_cnt;
        req_t        e;
        will_accept = i_req_valid && o_req_ready;
        nxt_req     = '{i_req_we, i_req_addr, i_req_wdata};
        @(posedge clk);
        #1;
        if (will_accept) model_q.push_back(nxt_req);
        if (ack_drv) begin
            waiting  = 1'b1;
            done_cnt = 0;
            chk("valid_drop_after_ack", o_cmd_valid, 0);
        end
        if (done_drv) begin
            waiting = 1'b0;
            chk("rsp_valid_on_done", o_rsp_valid, {63'd0, !cur.we});
            if (!cur.we) chk("rsp_rdata", o_rsp_rdata, done_data);
        end else begin
            chk("rsp_valid_quiet", o_rsp_valid, 0);
        end
        if (o_rsp_valid) begin
            last_rsp = o_rsp_rdata;
            rsp_cnt++;
        end
        if (o_cmd_valid && !prev_valid) begin
            if (model_q.size() == 0) begin
                chk("unexpected_issue", o_cmd_valid, 0);
            end else begin
                e = model_q.pop_front();
                chk("issue_we", o_cmd_we, e.we);
                chk("issue_addr", o_cmd_addr, e.addr);
                chk("issue_wdata", o_cmd_wdata, e.wdata);
                cur     = e;
                ack_cnt = 0;
                hi_len  = 1;
                waiting = 1'b0;
                issued++;
                if (rand_delays) begin
                    ack_delay  = $urandom_range(0, 3);
                    done_delay = $urandom_range(0, 5);
                end
            end
        end else if (o_cmd_valid) begin
            hi_len++;
            chk("hold_we", o_cmd_we, cur.we);
            chk("hold_addr", o_cmd_addr, cur.addr);
            chk("hold_wdata", o_cmd_wdata, cur.wdata);
        end
        prev_valid = o_cmd_valid;
        // One popped entry may sit in the holding register before valid rises.
        pending = model_q.size();
        exp_cnt = pending;
        if (pending > 0 && o_q_count == 4'(pending - 1)) exp_cnt = pending - 1;
        chk("q_count", o_q_count, exp_cnt);
        chk("q_empty", o_q_empty, o_q_count == 0);
        chk("q_full", o_q_full, o_q_count == DEPTH);
        chk("req_ready", o_req_ready, o_q_count != DEPTH);
        ack_drv  = 1'b0;
        done_drv = 1'b0;
        if (o_cmd_valid) begin
            if (!hold_ack) begin
                if (ack_cnt >= ack_delay) ack_drv = 1'b1;
                else ack_cnt++;
            end
        end else if (waiting && !hold_done) begin
            if (done_cnt >= done_delay) begin
                done_drv  = 1'b1;
                done_data = fixed_rdata_en ? fixed_rdata : {$urandom, $urandom};
            end else begin
                done_cnt++;
            end
        end
        i_cmd_ack   = ack_drv;
        i_cmd_done  = done_drv;
        i_cmd_rdata = done_drv ? done_data : {$urandom, $urandom};
    endtask

    task automatic drive_req(input bit v, input bit we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        i_req_valid = v;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = d;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((model_q.size() != 0 || o_cmd_valid || waiting || !o_q_empty) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, n < budget, 1);
    endtask

    initial begin
        int iss0, rsp0;
        rst_n = 1'b0;
        drive_req(0, 0, '0, '0);
        i_cmd_ack = 0; i_cmd_done = 0; i_cmd_rdata = '0;
        ack_delay = 0; done_delay = 0; ack_cnt = 0; done_cnt = 0;
        hold_ack = 0; hold_done = 0; rand_delays = 0; fixed_rdata_en = 0;
        fixed_rdata = '0; done_data = '0; last_rsp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", o_cmd_valid, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_cmd_addr", o_cmd_addr, 0);
        chk("rst_q_count", o_q_count, 0);
        chk("rst_q_empty", o_q_empty, 1);
        chk("rst_req_ready", o_req_ready, 1);
`ifdef CMD_TIMEOUT_EN
        chk("rst_timeout_err", o_timeout_err, 0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: single write, valid two edges after the push edge
        ack_delay = 0; done_delay = 3;
        drive_req(1, 1, 27'h100, 64'hA5A5_0000_0000_5A5A);
        rsp0 = rsp_cnt;
        tick();
        drive_req(0, 0, '0, '0);
        chk("t1_valid_push_edge", o_cmd_valid, 0);
        tick();
        chk("t1_valid_plus1", o_cmd_valid, 0);
        tick();
        chk("t1_valid_plus2", o_cmd_valid, 1);
        drain("t1", 50);
        chk("t1_no_rsp", rsp_cnt - rsp0, 0);
        chk("t1_empty_end", o_q_empty, 1);

        // 2: read response carries the controller data
        fixed_rdata_en = 1; fixed_rdata = 64'h1234_5678_9ABC_DEF0;
        rsp0 = rsp_cnt;
        drive_req(1, 0, 27'h200, {$urandom, $urandom});
        tick();
        drive_req(0, 0, '0, '0);
        drain("t2", 50);
        fixed_rdata_en = 0;
        chk("t2_rsp_count", rsp_cnt - rsp0, 1);
        chk("t2_rsp_data", last_rsp, 64'h1234_5678_9ABC_DEF0);

        // 3: fill with ack held low, refuse the tenth, retire in order
        hold_ack = 1;
        iss0 = issued;
        for (int i = 0; i < 9; i++) begin
            drive_req(1, i[0], 27'(32'h1000 + i * 64), {$urandom, $urandom});
            tick();
        end
        drive_req(1, 1, 27'h7FF_FFC0, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("t3_count_full", o_q_count, 8);
        chk("t3_full", o_q_full, 1);
        chk("t3_ready_low", o_req_ready, 0);
        tick();
        drive_req(0, 0, '0, '0);
        chk("t3_tenth_refused", o_q_count, 8);
        hold_ack = 0; ack_delay = 1; done_delay = 2;
        drain("t3", 300);
        chk("t3_issued", issued - iss0, 9);

        // 4: ack delayed 5 cycles, command held stable, valid drops after ack
        ack_delay = 5; done_delay = 2;
        drive_req(1, 1, 27'h0AB_CDE0, 64'h0F0F_F0F0_1234_4321);
        tick();
        drive_req(0, 0, '0, '0);
        drain("t4", 60);
        chk("t4_valid_width", hi_len, 6);

        // 5: reset while in WAIT_DONE with three queued
        ack_delay = 0; hold_done = 1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1, 0, 27'(32'h300 + i * 8), {$urandom, $urandom});
            tick();
        end
        drive_req(0, 0, '0, '0);
        for (int n = 0; n < 20 && !(waiting && o_q_count == 3); n++) tick();
        chk("t5_waiting_three", o_q_count, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_count", o_q_count, 0);
        chk("t5_async_empty", o_q_empty, 1);
        chk("t5_async_cmd_valid", o_cmd_valid, 0);
        chk("t5_async_rsp_valid", o_rsp_valid, 0);
        chk("t5_async_ready", o_req_ready, 1);
        model_q.delete();
        waiting = 0; prev_valid = 0; ack_drv = 0; done_drv = 0; hold_done = 0;
        i_cmd_ack = 0; i_cmd_done = 0;
        tick();
        rst_n = 1'b1;
        iss0 = issued;
        drive_req(1, 0, 27'h440, '0);
        tick();
        drive_req(0, 0, '0, '0);
        drain("t5", 50);
        chk("t5_post_reset_issued", issued - iss0, 1);

`ifdef CMD_TIMEOUT_EN
        // 6: withheld done trips the watchdog after 16 WAIT_DONE cycles
        ack_delay = 0; hold_done = 1;
        iss0 = issued;
        drive_req(1, 1, 27'h500, {$urandom, $urandom});
        tick();
        drive_req(1, 1, 27'h540, {$urandom, $urandom});
        tick();
        drive_req(0, 0, '0, '0);
        for (int n = 0; n < 20 && !waiting; n++) tick();
        for (int n = 0; n < 15; n++) tick();
        chk("t6_err_before_limit", o_timeout_err, 0);
        tick();
        chk("t6_err_at_limit", o_timeout_err, 1);
        waiting = 0; hold_done = 0;
        drain("t6", 60);
        chk("t6_next_issued", issued - iss0, 2);
        chk("t6_err_sticky", o_timeout_err, 1);
`endif

        // randomized traffic against the model
        rand_delays = 1;
        rsp0 = rsp_cnt;
        for (int n = 0; n < 400; n++) begin
            drive_req($urandom_range(0, 2) != 0, $urandom_range(0, 1),
                      27'($urandom), {$urandom, $urandom});
            tick();
        end
        drive_req(0, 0, '0, '0);
        drain("rand", 2000);
        chk("rand_model_empty", model_q.size(), 0);
        chk("rand_q_empty", o_q_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog observed=running expected=finished");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
